// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
//   Round-robin arbiter that lets three byte-stream requesters share one UART
//   transmitter. A granted requester keeps the UART until the byte flagged as
//   last has been sent, or until a byte is not acknowledged within TIMEOUT
//   cycles. A timeout drops the rest of that message.
//
// Ports
//   clk          clock, all state on the rising edge
//   reset        asynchronous reset, active low
//   req[2:0]     per-requester "byte available"
//   req_data     byte of requester i on [8i+7:8i]
//   req_last     per-requester "current byte ends the message"
//   req_ack      one-cycle pulse: requester's byte taken
//   grant        one-hot owner of the UART, 0 when idle
//   tx_data      byte to the UART
//   tx_start     one-cycle pulse: transmit tx_data
//   tx_done      one-cycle pulse from the UART: byte sent
//   busy         high whenever the arbiter is not idle
//   err_timeout  sticky timeout flag, cleared only by reset
module uart_tx_arbiter #(
    parameter int unsigned TIMEOUT = 20000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [2:0]  req,
    input  logic [23:0] req_data,
    input  logic [2:0]  req_last,
    output logic [2:0]  req_ack,
    output logic [2:0]  grant,
    output logic [7:0]  tx_data,
    output logic        tx_start,
    input  logic        tx_done,
    output logic        busy,
    output logic        err_timeout
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        WAIT = 2'd2
    } state_e;

    localparam logic [15:0] TIMER_LAST = 16'(TIMEOUT - 1);

    state_e      state_q;
    logic [1:0]  last_grant_q;
    logic [1:0]  gidx_q;
    logic        last_q;
    logic [15:0] timer_q;
    logic [2:0]  grant_q;
    logic [2:0]  req_ack_q;
    logic [7:0]  tx_data_q;
    logic        tx_start_q;
    logic        busy_q;
    logic        err_q;

    logic [1:0]  pick_d;
    logic        pick_vld_d;
    logic [1:0]  cand_d;

    // Round robin: first requesting index searching upward modulo 3,
    // starting just after the previous owner.
    always_comb begin
        pick_d     = '0;
        pick_vld_d = 1'b0;
        cand_d     = '0;
        for (int unsigned i = 1; i <= 3; i++) begin
            cand_d = 2'((32'(last_grant_q) + i) % 3);
            if (!pick_vld_d && req[cand_d]) begin
                pick_d     = cand_d;
                pick_vld_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            last_grant_q <= 2'd2;
            gidx_q       <= '0;
            last_q       <= 1'b0;
            timer_q      <= '0;
            grant_q      <= '0;
            req_ack_q    <= '0;
            tx_data_q    <= '0;
            tx_start_q   <= 1'b0;
            busy_q       <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            // Pulses last exactly one cycle: the first cycle of WAIT.
            tx_start_q <= 1'b0;
            req_ack_q  <= '0;
            case (state_q)
                IDLE: begin
                    if (pick_vld_d) begin
                        gidx_q  <= pick_d;
                        grant_q <= 3'b001 << pick_d;
                        busy_q  <= 1'b1;
                        state_q <= SEND;
                    end else begin
                        grant_q <= '0;
                    end
                end
                SEND: begin
                    // Owner withdrew its request: hold the lock, emit nothing.
                    if (req[gidx_q]) begin
                        tx_data_q  <= req_data[{gidx_q, 3'b000} +: 8];
                        tx_start_q <= 1'b1;
                        req_ack_q  <= grant_q;
                        last_q     <= req_last[gidx_q];
                        timer_q    <= '0;
                        state_q    <= WAIT;
                    end
                end
                WAIT: begin
                    // tx_done takes priority over a simultaneous timeout.
                    if (tx_done) begin
                        if (last_q) begin
                            last_grant_q <= gidx_q;
                            grant_q      <= '0;
                            busy_q       <= 1'b0;
                            state_q      <= IDLE;
                        end else begin
                            state_q <= SEND;
                        end
                    end else if (timer_q == TIMER_LAST) begin
                        err_q        <= 1'b1;
                        last_grant_q <= gidx_q;
                        grant_q      <= '0;
                        busy_q       <= 1'b0;
                        state_q      <= IDLE;
                    end else begin
                        timer_q <= timer_q + 16'd1;
                    end
                end
                default: begin
                    grant_q <= '0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign req_ack     = req_ack_q;
    assign grant       = grant_q;
    assign tx_data     = tx_data_q;
    assign tx_start    = tx_start_q;
    assign busy        = busy_q;
    assign err_timeout = err_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: three requester models fed from byte queues, a
// UART model answering tx_start with tx_done after a programmable delay, and a
// scoreboard of {owner, byte} expected at each tx_start.
module tb_uart_tx_arbiter;

    localparam int unsigned TO = 8;

    logic        clk      = 1'b0;
    logic        reset    = 1'b0;
    logic [2:0]  req      = '0;
    logic [23:0] req_data = '0;
    logic [2:0]  req_last = '0;
    logic [2:0]  req_ack;
    logic [2:0]  grant;
    logic [7:0]  tx_data;
    logic        tx_start;
    logic        tx_done  = 1'b0;
    logic        busy;
    logic        err_timeout;

    uart_tx_arbiter #(.TIMEOUT(TO)) dut (
        .clk         (clk),
        .reset       (reset),
        .req         (req),
        .req_data    (req_data),
        .req_last    (req_last),
        .req_ack     (req_ack),
        .grant       (grant),
        .tx_data     (tx_data),
        .tx_start    (tx_start),
        .tx_done     (tx_done),
        .busy        (busy),
        .err_timeout (err_timeout)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;

    always @(posedge clk) cyc <= cyc + 1;

    logic [8:0] rq [3][$];      // {last, data} per requester
    logic [2:0] hold = '0;      // force req[i] low while set
    logic [9:0] sb [$];         // expected {owner, byte}
    int         n_starts = 0;
    int         ack_cnt [3];
    int         start_log [$];
    int         done_log [$];
    int         rise_cyc [3];
    int         last_start_cyc = 0;
    int         pend     = 0;
    int         done_dly = 5;
    logic       uart_en  = 1'b1;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic check_rst(input string tag);
        check_eq({tag, "_grant"},    32'(grant),       32'd0);
        check_eq({tag, "_tx_data"},  32'(tx_data),     32'd0);
        check_eq({tag, "_tx_start"}, 32'(tx_start),    32'd0);
        check_eq({tag, "_req_ack"},  32'(req_ack),     32'd0);
        check_eq({tag, "_busy"},     32'(busy),        32'd0);
        check_eq({tag, "_err"},      32'(err_timeout), 32'd0);
    endtask

    task automatic push(input int i, input logic [7:0] d, input logic l, input logic sent = 1'b1);
        rq[i].push_back({l, d});
        if (sent) sb.push_back({2'(i), d});
    endtask

    function automatic int pending();
        return sb.size() + rq[0].size() + rq[1].size() + rq[2].size() + int'(busy);
    endfunction

    task automatic wait_done(input string tag, input int budget);
        for (int k = 0; k < budget; k++) begin
            @(negedge clk);
            if (pending() == 0) break;
        end
        check_eq({tag, "_drained"}, 32'(pending()), 32'd0);
    endtask

    task automatic wait_start(input string tag, input int budget);
        int s0;
        s0 = n_starts;
        for (int k = 0; k < budget; k++) begin
            @(negedge clk);
            if (n_starts != s0) break;
        end
        check_eq({tag, "_start_seen"}, 32'(n_starts != s0), 32'd1);
    endtask

    task automatic do_reset(input string tag);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check_rst(tag);
        pend    = 0;
        tx_done = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
    endtask

    // Requester models: pop on ack, present head byte from the next cycle.
    // Non-requesting lanes carry random junk that must never reach the UART.
    initial begin
        forever begin
            @(negedge clk);
            for (int i = 0; i < 3; i++) begin
                if (req_ack[i] && rq[i].size() > 0) void'(rq[i].pop_front());
                if (rq[i].size() > 0 && !hold[i]) begin
                    if (!req[i]) rise_cyc[i] = cyc;
                    req[i]             = 1'b1;
                    req_data[8*i +: 8] = rq[i][0][7:0];
                    req_last[i]        = rq[i][0][8];
                end else begin
                    req[i]             = 1'b0;
                    req_data[8*i +: 8] = 8'($urandom);
                    req_last[i]        = 1'($urandom);
                end
            end
        end
    end

    // UART model.
    initial begin
        forever begin
            @(negedge clk);
            tx_done = 1'b0;
            if (pend > 0) begin
                pend--;
                if (pend == 0) begin
                    tx_done = 1'b1;
                    done_log.push_back(cyc);
                end
            end
            if (tx_start && uart_en) pend = done_dly;
        end
    end

    // Output monitor / scoreboard.
    initial begin
        logic [9:0] e;
        logic [2:0] oh;
        forever begin
            @(negedge clk);
            if (reset && tx_start) begin
                e  = (sb.size() > 0) ? sb.pop_front() : 10'h3FF;
                oh = 3'b001 << e[9:8];
                check_eq("tx_data", 32'(tx_data), 32'(e[7:0]));
                check_eq("tx_owner", 32'(grant), 32'(oh));
                check_eq("ack_eq_grant", 32'(req_ack), 32'(grant));
                n_starts++;
                last_start_cyc = cyc;
                start_log.push_back(cyc);
            end
            for (int i = 0; i < 3; i++) if (req_ack[i]) ack_cnt[i]++;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int s0;
        int a0;
        int lat;
        int spc;
        for (int i = 0; i < 3; i++) begin
            ack_cnt[i]  = 0;
            rise_cyc[i] = 0;
        end

        repeat (3) @(negedge clk);
        check_rst("por");
        reset = 1'b1;

        // Single requester, two-byte message.
        @(posedge clk);
        s0 = n_starts;
        a0 = ack_cnt[0];
        start_log.delete();
        done_log.delete();
        push(0, 8'h31, 1'b0);
        push(0, 8'h32, 1'b1);
        wait_done("t1", 100);
        check_eq("t1_starts", 32'(n_starts - s0), 32'd2);
        check_eq("t1_acks0", 32'(ack_cnt[0] - a0), 32'd2);
        check_eq("t1_grant", 32'(grant), 32'd0);
        check_eq("t1_busy", 32'(busy), 32'd0);
        lat = (start_log.size() > 0) ? start_log[0] - rise_cyc[0] : -1;
        spc = (start_log.size() > 1 && done_log.size() > 0) ? start_log[1] - done_log[0] : -1;
        check_eq("t1_latency", 32'(lat), 32'd2);
        check_eq("t1_spacing", 32'(spc), 32'd2);

        // Simultaneous one-byte requests, twice.
        do_reset("t2rst");
        @(posedge clk);
        push(0, 8'hA0, 1'b1);
        push(1, 8'hA1, 1'b1);
        push(2, 8'hA2, 1'b1);
        wait_done("t2a", 200);
        @(posedge clk);
        push(0, 8'hB0, 1'b1);
        push(1, 8'hB1, 1'b1);
        push(2, 8'hB2, 1'b1);
        wait_done("t2b", 200);

        // Requester 1 three-byte message with requester 2 waiting throughout.
        @(posedge clk);
        push(1, 8'hC1, 1'b0);
        push(1, 8'hC2, 1'b0);
        push(1, 8'hC3, 1'b1);
        push(2, 8'hD0, 1'b1);
        wait_done("t3", 200);

        // Owner drops req mid-message: SEND held, no other requester served.
        @(posedge clk);
        s0 = n_starts;
        push(0, 8'hE1, 1'b0);
        push(0, 8'hE2, 1'b1);
        wait_start("t4", 20);
        hold[0] = 1'b1;
        push(1, 8'hF1, 1'b1);
        repeat (12) @(negedge clk);
        check_eq("t4_held_starts", 32'(n_starts - s0), 32'd1);
        check_eq("t4_held_grant", 32'(grant), 32'b001);
        check_eq("t4_held_busy", 32'(busy), 32'd1);
        hold[0] = 1'b0;
        wait_done("t4", 200);
        check_eq("t4_starts", 32'(n_starts - s0), 32'd3);

        // Timeout: UART never answers.
        uart_en = 1'b0;
        @(posedge clk);
        push(2, 8'h71, 1'b0);
        push(2, 8'h72, 1'b1, 1'b0);
        wait_start("t5", 20);
        push(0, 8'h81, 1'b1);
        for (int k = 0; k < 20; k++) begin
            if (err_timeout) break;
            @(negedge clk);
        end
        check_eq("t5_err", 32'(err_timeout), 32'd1);
        check_eq("t5_err_cycle", 32'(cyc - last_start_cyc), 32'd8);
        check_eq("t5_grant", 32'(grant), 32'd0);
        check_eq("t5_busy", 32'(busy), 32'd0);
        rq[2].delete();
        uart_en = 1'b1;
        wait_done("t5", 100);
        check_eq("t5_err_sticky", 32'(err_timeout), 32'd1);

        // tx_done in the timeout cycle wins.
        do_reset("t6rst");
        done_dly = int'(TO) - 1;
        @(posedge clk);
        s0 = n_starts;
        push(0, 8'h51, 1'b0);
        push(0, 8'h52, 1'b1);
        wait_done("t6", 100);
        check_eq("t6_err", 32'(err_timeout), 32'd0);
        check_eq("t6_starts", 32'(n_starts - s0), 32'd2);
        done_dly = 5;

        // Reset during WAIT, then power-up priority again.
        @(posedge clk);
        s0 = n_starts;
        push(1, 8'h61, 1'b0);
        push(1, 8'h62, 1'b1, 1'b0);
        wait_start("t7", 20);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        #1;
        check_rst("t7rst");
        for (int i = 0; i < 3; i++) rq[i].delete();
        check_eq("t7_sb", 32'(sb.size()), 32'd0);
        pend = 0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        repeat (15) @(negedge clk);
        check_eq("t7_no_start", 32'(n_starts - s0), 32'd1);
        check_eq("t7_grant", 32'(grant), 32'd0);
        @(posedge clk);
        push(0, 8'h90, 1'b1);
        push(2, 8'h92, 1'b1);
        wait_done("t7post", 200);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
